// File: rtl/xgmac_tx_arb.sv
// Packet-level round-robin arbiter merging NUM_CH AXI4-Stream sources onto the 10G MAC tx_axis port.
// Whole packets are granted, one registered output stage, per-channel forwarded-frame counters.
module xgmac_tx_arb #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 64,
    parameter int KEEP_W = 8,
    parameter int USER_W = 128,
    parameter int CH_W   = 3,
    parameter int CNT_W  = 32
) (
    input  logic                      clk156,
    input  logic                      reset,
    input  logic [NUM_CH*DATA_W-1:0]  s_axis_tdata,
    input  logic [NUM_CH*KEEP_W-1:0]  s_axis_tkeep,
    input  logic [NUM_CH*USER_W-1:0]  s_axis_tuser,
    input  logic [NUM_CH-1:0]         s_axis_tlast,
    input  logic [NUM_CH-1:0]         s_axis_tvalid,
    output logic [NUM_CH-1:0]         s_axis_tready,
    output logic [DATA_W-1:0]         m_axis_tdata,
    output logic [KEEP_W-1:0]         m_axis_tkeep,
    output logic [USER_W-1:0]         m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic [CH_W-1:0]           m_axis_tdest,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy,
    output logic [NUM_CH*CNT_W-1:0]   frame_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     gnt_q, gnt_d;
    logic [CH_W-1:0]     last_q, last_d;
    logic [CH_W-1:0]     pick;
    logic                any_req;
    logic                ld;
    logic                hs;

    logic                src_valid;
    logic [DATA_W-1:0]   src_data;
    logic [KEEP_W-1:0]   src_keep;
    logic [USER_W-1:0]   src_user;
    logic                src_last;

    logic [2*NUM_CH-1:0] req_rot;
    logic                found;

    logic [NUM_CH*CNT_W-1:0] cnt_q;

    // Rotate the doubled request vector so bit 0 is the channel just after the last grant;
    // the lowest set bit is then the round-robin winner.
    always_comb begin
        any_req = |s_axis_tvalid;
        req_rot = {s_axis_tvalid, s_axis_tvalid} >> (32'(last_q) + 32'd1);
        pick    = '0;
        found   = 1'b0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                pick  = CH_W'((32'(last_q) + 32'd1 + 32'(j)) % 32'(NUM_CH));
            end
        end
    end

    always_comb begin
        src_valid = 1'b0;
        src_data  = '0;
        src_keep  = '0;
        src_user  = '0;
        src_last  = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (gnt_q == CH_W'(c)) begin
                src_valid = s_axis_tvalid[c];
                src_data  = s_axis_tdata[c*DATA_W +: DATA_W];
                src_keep  = s_axis_tkeep[c*KEEP_W +: KEEP_W];
                src_user  = s_axis_tuser[c*USER_W +: USER_W];
                src_last  = s_axis_tlast[c];
            end
        end
    end

    assign ld   = !m_axis_tvalid || m_axis_tready;
    assign hs   = (state_q == XFER) && src_valid && ld;
    assign busy = (state_q == XFER);

    always_comb begin
        s_axis_tready = '0;
        if (state_q == XFER) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (gnt_q == CH_W'(c)) begin
                    s_axis_tready[c] = ld;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = XFER;
                    gnt_d   = pick;
                    last_d  = pick;
                end
            end
            XFER: begin
                if (hs && src_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Output register drains in any state, so a stalled final beat completes after we return to IDLE.
    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdest  <= '0;
            m_axis_tvalid <= 1'b0;
        end else if (hs) begin
            m_axis_tdata  <= src_data;
            m_axis_tkeep  <= src_keep;
            m_axis_tuser  <= src_user;
            m_axis_tlast  <= src_last;
            m_axis_tdest  <= gnt_q;
            m_axis_tvalid <= 1'b1;
        end else if (ld) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk156 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (m_axis_tdest == CH_W'(c)) begin
                    cnt_q[c*CNT_W +: CNT_W] <= cnt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_xgmac_tx_arb.sv
// Self-checking bench for xgmac_tx_arb (4 channels): per-channel beat scoreboards,
// round-robin order model, stall/hold rules, reset abort and counter wrap.
module tb_xgmac_tx_arb;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int UW = 16;
    localparam int CW = 3;
    localparam int NW = 32;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NC*DW-1:0]     s_tdata = '0;
    logic [NC*KW-1:0]     s_tkeep = '0;
    logic [NC*UW-1:0]     s_tuser = '0;
    logic [NC-1:0]        s_tlast = '0;
    logic [NC-1:0]        s_tvalid = '0;
    logic [NC-1:0]        s_tready;
    logic [DW-1:0]        m_tdata;
    logic [KW-1:0]        m_tkeep;
    logic [UW-1:0]        m_tuser;
    logic                 m_tlast;
    logic [CW-1:0]        m_tdest;
    logic                 m_tvalid;
    logic                 m_tready = 1'b0;
    logic                 busy;
    logic [NC*NW-1:0]     frame_cnt;

    xgmac_tx_arb #(
        .NUM_CH(NC), .DATA_W(DW), .KEEP_W(KW), .USER_W(UW), .CH_W(CW), .CNT_W(NW)
    ) dut (
        .clk156        (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .m_axis_tdest  (m_tdest),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    beat_t        srcq [NC][$];
    beat_t        expq [NC][$];
    bit           pres [NC];
    bit           stall_ch [NC];
    logic [NW-1:0] exp_cnt [NC];
    int           gap_pct = 0;
    int           rdy_pct = 100;
    bit           rdy_pat [$];
    int           order [$];
    int           exp_order [$];
    bit           in_pkt;
    int           cur_ch;
    bit           prev_stall;
    logic [DW-1:0] prev_data;
    logic         prev_last;
    logic [CW-1:0] prev_dest;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit all_empty();
        for (int c = 0; c < NC; c++)
            if (srcq[c].size() != 0 || expq[c].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen_pkt(input int c, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {$urandom, $urandom};
            b.k = 8'($urandom);
            b.u = 16'($urandom);
            b.l = (i == len - 1);
            srcq[c].push_back(b);
            expq[c].push_back(b);
        end
        exp_cnt[c] = exp_cnt[c] + 1;
    endtask

    task automatic check_out();
        beat_t b;
        int c;
        c = int'(m_tdest);
        chk("tdest_range", 128'(c < NC), 1);
        if (c < NC) begin
            if (in_pkt) chk("no_interleave", m_tdest, 3'(cur_ch));
            else begin
                order.push_back(c);
                in_pkt = 1'b1;
                cur_ch = c;
            end
            chk("beat_expected", 128'(expq[c].size() != 0), 1);
            if (expq[c].size() != 0) begin
                b = expq[c].pop_front();
                chk("tdata", m_tdata, b.d);
                chk("tkeep", m_tkeep, b.k);
                chk("tuser", m_tuser, b.u);
                chk("tlast", m_tlast, b.l);
            end
            if (m_tlast) in_pkt = 1'b0;
        end
    endtask

    // One clock: drive at the falling edge, settle, then sample handshakes the next rising edge will take.
    task automatic step();
        beat_t b;
        @(negedge clk);
        for (int c = 0; c < NC; c++) begin
            if (!pres[c] && srcq[c].size() != 0 && !stall_ch[c] && $urandom_range(0, 99) >= gap_pct)
                pres[c] = 1'b1;
            s_tvalid[c] = pres[c];
            if (pres[c]) begin
                b = srcq[c][0];
                s_tdata[c*DW +: DW] = b.d;
                s_tkeep[c*KW +: KW] = b.k;
                s_tuser[c*UW +: UW] = b.u;
                s_tlast[c]          = b.l;
            end
        end
        if (rdy_pat.size() != 0) m_tready = rdy_pat.pop_front();
        else m_tready = ($urandom_range(0, 99) < rdy_pct);
        #1;
        chk("ready_onehot", 128'($countones(s_tready) <= 1), 1);
        if (m_tvalid && !m_tready) chk("ready_while_stalled", s_tready, 0);
        if (prev_stall) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, prev_data);
            chk("hold_last", m_tlast, prev_last);
            chk("hold_dest", m_tdest, prev_dest);
        end
        if (m_tvalid && m_tready) check_out();
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        prev_last  = m_tlast;
        prev_dest  = m_tdest;
        for (int c = 0; c < NC; c++) begin
            if (s_tvalid[c] && s_tready[c]) begin
                void'(srcq[c].pop_front());
                pres[c] = 1'b0;
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (n < bound && !(all_empty() && !m_tvalid)) begin
            step();
            n++;
        end
        chk("drain_in_time", 128'(n < bound), 1);
        chk("idle_after_drain", busy, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        for (int c = 0; c < NC; c++) begin
            srcq[c].delete();
            expq[c].delete();
            pres[c]     = 1'b0;
            stall_ch[c] = 1'b0;
            exp_cnt[c]  = '0;
        end
        s_tvalid   = '0;
        order.delete();
        in_pkt     = 1'b0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_counts(input string tag);
        for (int c = 0; c < NC; c++) chk(tag, frame_cnt[c*NW +: NW], exp_cnt[c]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int rem [NC];
        int last;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tdest", m_tdest, 0);
        chk("rst_sready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        apply_reset();

        // Single 3-beat packet on ch0: output valid two cycles after source valid
        gap_pct = 0;
        rdy_pct = 100;
        gen_pkt(0, 3);
        first = -1;
        for (int k = 0; k < 6; k++) begin
            step();
            if (m_tvalid && first < 0) first = k;
        end
        chk("t1_latency", 128'(first), 2);
        drain(50);
        chk("t1_order_len", 128'(order.size()), 1);
        if (order.size() != 0) chk("t1_tdest", 128'(order[0]), 0);
        check_counts("t1_frame_cnt");

        // All channels continuously offering 2-beat packets: strict round robin from ch0
        apply_reset();
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < NC; c++) gen_pkt(c, 2);
        for (int c = 0; c < NC; c++) rem[c] = 2;
        last = NC - 1;
        exp_order.delete();
        for (int k = 0; k < 2 * NC; k++) begin
            for (int i = 1; i <= NC; i++) begin
                if (rem[(last + i) % NC] > 0) begin
                    last = (last + i) % NC;
                    rem[last]--;
                    exp_order.push_back(last);
                    break;
                end
            end
        end
        drain(200);
        chk("t2_order_len", 128'(order.size()), 128'(2 * NC));
        for (int k = 0; k < 2 * NC && k < order.size(); k++) chk("t2_rr_order", 128'(order[k]), 128'(exp_order[k]));
        check_counts("t2_frame_cnt");

        // ch1 packet with a downstream stall pattern
        order.delete();
        gen_pkt(1, 5);
        for (int n = 0; n < 20 && !m_tvalid; n++) step();
        chk("t3_started", m_tvalid, 1);
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        drain(50);
        check_counts("t3_frame_cnt");

        // ch0 pauses mid-packet; ch1 must wait for ch0's tlast
        order.delete();
        gen_pkt(0, 4);
        for (int n = 0; n < 20 && srcq[0].size() != 3; n++) step();
        stall_ch[0] = 1'b1;
        gen_pkt(1, 2);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("t4_ch1_blocked", s_tready[1], 0);
            chk("t4_busy", busy, 1);
        end
        stall_ch[0] = 1'b0;
        drain(50);
        chk("t4_order_len", 128'(order.size()), 2);
        if (order.size() == 2) begin
            chk("t4_first", 128'(order[0]), 0);
            chk("t4_second", 128'(order[1]), 1);
        end

        // Randomized traffic with gaps and backpressure
        gap_pct = 30;
        rdy_pct = 70;
        for (int p = 0; p < 3; p++)
            for (int c = 0; c < NC; c++) gen_pkt(c, $urandom_range(1, 6));
        drain(3000);
        check_counts("rand_frame_cnt");

        // Reset during beat 2 of a 4-beat packet
        gap_pct = 0;
        rdy_pct = 100;
        gen_pkt(0, 4);
        for (int n = 0; n < 20 && srcq[0].size() != 2; n++) step();
        reset = 1'b1;
        #1;
        chk("t5_tvalid_async", m_tvalid, 0);
        chk("t5_sready_async", s_tready, 0);
        chk("t5_busy_async", busy, 0);
        chk("t5_frame_cnt_async", frame_cnt, 0);
        apply_reset();
        gen_pkt(2, 2);
        gen_pkt(0, 2);
        drain(50);
        chk("t5_order_len", 128'(order.size()), 2);
        if (order.size() == 2) begin
            chk("t5_first_ch0", 128'(order[0]), 0);
            chk("t5_second_ch2", 128'(order[1]), 2);
        end
        check_counts("t5_frame_cnt");

        // Counter wrap from all-ones
        force dut.cnt_q = {exp_cnt[3], exp_cnt[2], exp_cnt[1], 32'hFFFF_FFFF};
        #1;
        release dut.cnt_q;
        exp_cnt[0] = 32'hFFFF_FFFF;
        gen_pkt(0, 1);
        drain(50);
        chk("t6_wrap", frame_cnt[NW-1:0], exp_cnt[0]);
        check_counts("t6_frame_cnt");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
